// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG harvester: FSM encoding, word width,
// default parameter values.
package trng_pkg;

  localparam int TRNG_W             = 32;
  localparam int DEF_OUT_WORDS      = 2;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_REPEAT_LIMIT   = 3;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/trng_fifo.sv
// Synchronous first-word-fall-through FIFO; head is valid whenever level != 0.
module trng_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (level_q != '0);
    // A push into a full FIFO is only honoured when a pop frees the slot.
    do_push  = push && ((level_q != LW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (level_q != '0);
  assign level = level_q;

endmodule

// File: rtl/trng_harvester.sv
// Requests words from a TRNG core, runs a repetition health test, assembles
// OUT_WORDS captures per output word and queues them in a FWFT FIFO.
module trng_harvester
  import trng_pkg::*;
#(
  parameter int OUT_WORDS      = DEF_OUT_WORDS,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int REPEAT_LIMIT   = DEF_REPEAT_LIMIT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            clear_fail,
  output logic                            trng_request,
  input  logic [TRNG_W-1:0]               trng_random_number,
  input  logic                            trng_ready,
  output logic [TRNG_W*OUT_WORDS-1:0]     out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            health_fail,
  output logic                            timeout_err
);

  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam int SW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

  state_e                             state_q, state_d;
  logic                               req_q;
  logic [TW-1:0]                      tmo_q, tmo_d;
  logic [SW-1:0]                      slot_q, slot_d;
  logic [OUT_WORDS-1:0][TRNG_W-1:0]   asm_q, asm_d;
  logic                               push_q, push_d;
  logic [TRNG_W-1:0]                  prev_q, prev_d;
  logic                               prev_vld_q, prev_vld_d;
  logic [7:0]                         rep_q, rep_d;
  logic                               hfail_q, hfail_d;
  logic                               terr_q, terr_d;

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    slot_d     = slot_q;
    asm_d      = asm_q;
    push_d     = 1'b0;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    rep_d      = rep_q;
    hfail_d    = hfail_q;
    terr_d     = terr_q;
    unique case (state_q)
      ST_IDLE: begin
        // Entry gating on level plus a single assembly in flight keeps pushes off a full FIFO.
        if (enable && !hfail_q && (fifo_level < LW'(FIFO_DEPTH)) && !clear_fail)
          state_d = ST_REQ;
      end
      ST_REQ: begin
        if (trng_ready) begin
          state_d    = ST_GAP;
          tmo_d      = '0;
          rep_d      = (prev_vld_q && (trng_random_number == prev_q)) ? rep_q + 8'd1 : 8'd0;
          prev_d     = trng_random_number;
          prev_vld_d = 1'b1;
          if (rep_d == 8'(REPEAT_LIMIT-1)) begin
            hfail_d = 1'b1;
            slot_d  = '0;
          end else begin
            asm_d[slot_q] = trng_random_number;
            if (slot_q == SW'(OUT_WORDS-1)) begin
              slot_d = '0;
              push_d = 1'b1;
            end else begin
              slot_d = slot_q + SW'(1);
            end
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES-1)) begin
          state_d = ST_GAP;
          tmo_d   = '0;
          terr_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (!trng_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear_fail) begin
      hfail_d    = 1'b0;
      terr_d     = 1'b0;
      rep_d      = '0;
      prev_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      tmo_q      <= '0;
      slot_q     <= '0;
      push_q     <= 1'b0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      rep_q      <= '0;
      hfail_q    <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= (state_d == ST_REQ);
      tmo_q      <= tmo_d;
      slot_q     <= slot_d;
      push_q     <= push_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      rep_q      <= rep_d;
      hfail_q    <= hfail_d;
      terr_q     <= terr_d;
    end
  end

  // Assembly data needs no reset: the slot index alone decides what is pushed.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  trng_fifo #(
    .WIDTH (TRNG_W*OUT_WORDS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (asm_q),
    .pop       (out_valid && out_ready),
    .head      (out_data),
    .valid     (out_valid),
    .level     (fifo_level)
  );

  assign trng_request = req_q;
  assign health_fail  = hfail_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_trng_harvester.sv
// Directed bench for trng_harvester: word assembly, FIFO backpressure,
// health test, timeout, reset mid-assembly and enable handling.
module tb_trng_harvester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clear_fail;
  logic        trng_request;
  logic [31:0] trng_random_number;
  logic        trng_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic        health_fail;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trng_harvester #(
    .OUT_WORDS      (2),
    .FIFO_DEPTH     (4),
    .REPEAT_LIMIT   (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .clear_fail         (clear_fail),
    .trng_request       (trng_request),
    .trng_random_number (trng_random_number),
    .trng_ready         (trng_ready),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .fifo_level         (fifo_level),
    .health_fail        (health_fail),
    .timeout_err        (timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a request, then answer it with one ready cycle.
  task automatic serve(input logic [31:0] w);
    int n = 0;
    while (!trng_request && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!trng_request) chk("serve_req_seen", 64'd0, 64'd1);
    else begin
      trng_random_number = w;
      trng_ready = 1'b1;
      @(negedge clk);
      trng_ready = 1'b0;
    end
  endtask

  task automatic watch_req(input int cycles, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (trng_request) seen = 1'b1;
    end
  endtask

  initial begin
    logic seen;
    int   cnt;
    logic hit;
    rst_n = 1'b0; enable = 1'b0; clear_fail = 1'b0;
    trng_random_number = '0; trng_ready = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req",    64'(trng_request), 64'd0);
    chk("rst_valid",  64'(out_valid),    64'd0);
    chk("rst_level",  64'(fifo_level),   64'd0);
    chk("rst_hfail",  64'(health_fail),  64'd0);
    chk("rst_terr",   64'(timeout_err),  64'd0);
    rst_n = 1'b1;
    enable = 1'b1;

    // Basic assembly: word 0 in the low half.
    serve(32'h11111111);
    serve(32'h22222222);
    @(negedge clk);
    chk("asm_valid", 64'(out_valid),  64'd1);
    chk("asm_data",  out_data,        64'h22222222_11111111);
    chk("asm_level", 64'(fifo_level), 64'd1);

    // Backpressure: fill to 4 entries.
    serve(32'h33333333); serve(32'h44444444);
    serve(32'h55555555); serve(32'h66666666);
    serve(32'h77777777); serve(32'h88888888);
    repeat (3) @(negedge clk);
    chk("full_level", 64'(fifo_level), 64'd4);
    chk("full_head",  out_data,        64'h22222222_11111111);
    watch_req(10, seen);
    chk("full_no_req", 64'(seen), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop_level", 64'(fifo_level), 64'd3);
    chk("pop_head",  out_data,        64'h44444444_33333333);
    watch_req(2, seen);
    chk("pop_req", 64'(seen), 64'd1);

    // Enable drop mid-REQ: handshake completes, partial word held.
    enable = 1'b0;
    chk("en_low_req_held", 64'(trng_request), 64'd1);
    serve(32'h99999999);
    watch_req(6, seen);
    chk("en_low_no_req", 64'(seen), 64'd0);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    out_ready = 1'b0;
    chk("drain_level", 64'(fifo_level), 64'd0);
    chk("drain_valid", 64'(out_valid),  64'd0);
    enable = 1'b1;
    serve(32'hAAAAAAAA);
    enable = 1'b0;
    @(negedge clk);
    chk("resume_data",  out_data,        64'hAAAAAAAA_99999999);
    chk("resume_level", 64'(fifo_level), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("resume_pop", 64'(fifo_level), 64'd0);

    // Health test: three identical captures.
    enable = 1'b1;
    serve(32'hDEADBEEF);
    serve(32'hDEADBEEF);
    serve(32'hDEADBEEF);
    chk("hf_set", 64'(health_fail), 64'd1);
    @(negedge clk);
    chk("hf_level", 64'(fifo_level), 64'd1);
    chk("hf_data",  out_data,        64'hDEADBEEF_DEADBEEF);
    watch_req(10, seen);
    chk("hf_no_req", 64'(seen), 64'd0);
    clear_fail = 1'b1;
    @(negedge clk);
    clear_fail = 1'b0;
    chk("hf_cleared", 64'(health_fail), 64'd0);

    // Timeout: leave the resumed request unanswered.
    cnt = 0;
    while (!trng_request && cnt < 4) begin
      @(negedge clk);
      cnt++;
    end
    chk("clr_req_resume", 64'(trng_request), 64'd1);
    cnt = 1;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        hit = 1'b1;
        break;
      end
      if (trng_request) cnt++;
    end
    chk("tmo_hit",    64'(hit),          64'd1);
    chk("tmo_cycles", 64'(cnt),          64'd16);
    chk("tmo_gap0",   64'(trng_request), 64'd0);
    @(negedge clk);
    chk("tmo_gap1",   64'(trng_request), 64'd0);
    watch_req(4, seen);
    chk("tmo_retry",  64'(seen),         64'd1);
    chk("tmo_sticky", 64'(timeout_err),  64'd1);

    // Reset after one of two words captured.
    serve(32'h12345678);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_req",   64'(trng_request), 64'd0);
    chk("rst2_valid", 64'(out_valid),    64'd0);
    chk("rst2_level", 64'(fifo_level),   64'd0);
    chk("rst2_hfail", 64'(health_fail),  64'd0);
    chk("rst2_terr",  64'(timeout_err),  64'd0);
    rst_n = 1'b1;
    serve(32'h0000AAAA);
    serve(32'h0000BBBB);
    enable = 1'b0;
    @(negedge clk);
    chk("rst2_data",  out_data,        64'h0000BBBB_0000AAAA);
    chk("rst2_lvl1",  64'(fifo_level), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trng_harvester.md
TRNG_HARVESTER -- requirements
Module: trng_harvester

Interface
REQ-001 Parameter OUT_WORDS, default 2: number of 32-bit TRNG words concatenated per output word; legal range 1..8.
REQ-002 Parameter FIFO_DEPTH, default 4: number of output-word entries; a power of two in 2..16.
REQ-003 Parameter REPEAT_LIMIT, default 3: count of identical consecutive captured words that trips the health test; legal range 2..255.
REQ-004 Parameter TIMEOUT_CYCLES, default 256: maximum number of REQ-state cycles allowed while waiting for trng_ready.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 enable  in  1  permits new TRNG requests.
REQ-008 clear_fail  in  1  single-cycle pulse that clears health_fail, timeout_err and the repetition count.
REQ-009 trng_request  out  1  request to the TRNG core.
REQ-010 trng_random_number  in  32  TRNG data, valid while trng_ready is high.
REQ-011 trng_ready  in  1  TRNG data valid.
REQ-012 out_data  out  32*OUT_WORDS  FIFO head; word 0 occupies bits [31:0].
REQ-013 out_valid  out  1  FIFO is not empty.
REQ-014 out_ready  in  1  consumer accepts out_data.
REQ-015 fifo_level  out  $clog2(FIFO_DEPTH+1)  number of occupied FIFO entries.
REQ-016 health_fail  out  1  sticky repetition-test failure.
REQ-017 timeout_err  out  1  sticky TRNG timeout flag.

Function
REQ-018 The FSM shall have three states: IDLE, REQ and GAP.
REQ-019 IDLE->REQ when enable=1, health_fail=0, fifo_level<FIFO_DEPTH and clear_fail=0.
REQ-020 In REQ, trng_request shall be 1, registered, with no combinational path from any input.
REQ-021 A capture occurs on each cycle in REQ with trng_ready=1; the FSM then goes to GAP.
REQ-022 In GAP, trng_request shall be 0; the FSM returns to IDLE on the first cycle with trng_ready=0, so the request is low for at least 1 cycle.
REQ-023 In REQ, a cycle counter shall run; at TIMEOUT_CYCLES cycles with no ready, set timeout_err and go to GAP with no capture; retries then continue normally.
REQ-024 A captured word fills the next assembly slot, word 0 first; when slot OUT_WORDS-1 fills, the assembled word is pushed into the FIFO in the following cycle and the slot index returns to 0.
REQ-025 Gating on fifo_level<FIFO_DEPTH at REQ entry, together with the single assembly in flight, shall guarantee that a push never meets a full FIFO.
REQ-026 Health test: rep_cnt increments when a capture equals the previous capture (after the first capture since reset or clear), and resets to 0 otherwise.
REQ-027 When rep_cnt reaches REPEAT_LIMIT-1, health_fail shall set on that capture, the partial assembly shall be discarded (slot index 0, no push), and no further requests shall be made.
REQ-028 clear_fail shall clear health_fail, timeout_err, rep_cnt and the previous-word-valid flag; it does not affect the FIFO.
REQ-029 FIFO is first-word-fall-through: out_valid=(fifo_level!=0); a pop occurs on out_valid&&out_ready; a push and a pop in the same cycle leave fifo_level unchanged.
REQ-030 enable deasserted in REQ or GAP lets the handshake complete; the partial assembly is retained and resumes when enable returns to 1.
REQ-031 Pointers wrap modulo FIFO_DEPTH; fifo_level never exceeds FIFO_DEPTH and never underflows.

Reset
REQ-032 While rst_n=0 at a clock edge: FSM=IDLE; trng_request, out_valid, health_fail and timeout_err = 0; fifo_level=0; pointers, slot index, rep_cnt and the timeout counter = 0.
REQ-033 Reset mid-handshake or mid-assembly shall drop all partial data; the output word that follows reset is built only from post-reset captures.
REQ-034 out_data is undefined while out_valid=0.

Structure
REQ-035 Package trng_pkg shall hold the FSM state enum, default parameter constants and the 32-bit TRNG word width constant.
REQ-036 One sub-module, trng_fifo, shall implement the synchronous FWFT FIFO parameterised by width and depth.

Verification (OUT_WORDS=2, FIFO_DEPTH=4, REPEAT_LIMIT=3, TIMEOUT_CYCLES=16)
REQ-037 TRNG model returns 0x11111111 then 0x22222222 -> out_valid=1 with out_data=0x22222222_11111111.
REQ-038 out_ready=0 for 8 captures -> fifo_level=4 and trng_request stays 0; one pop -> fifo_level=3 and a request follows within 2 cycles.
REQ-039 Model returns 0xDEADBEEF three times -> health_fail=1 after the third capture, no push, requests stop; clear_fail pulse -> requests resume.
REQ-040 trng_ready held at 0 -> timeout_err=1 after 16 REQ cycles, trng_request low for at least 1 cycle, then a retry.
REQ-041 rst_n=0 after 1 of 2 words captured -> all outputs at reset values; next out_data is formed from 2 fresh captures.
REQ-042 enable dropped during REQ -> the handshake completes and the word is held; no new request until enable=1.
